// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the instruction loader.
// The slave modport is the loader; the master modport is the stream source and memory side.
interface instruction_loader_if;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        memWriteEnable;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;

  modport master (
    output byteIn, byteValid,
    input  byteReady, memWriteEnable, memAddress, memWriteData
  );

  modport slave (
    input  byteIn, byteValid,
    output byteReady, memWriteEnable, memAddress, memWriteData
  );
endinterface

// File: rtl/instruction_loader.sv
// Loads a framed program image (count, big-endian words, XOR checksum) into instruction memory
// and holds the CPU off while the load is in progress or has failed.
module instruction_loader #(
  parameter int          DEPTH        = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  instruction_loader_if.slave     bus,
  output logic                    o_cpuHold,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic [$clog2(DEPTH):0]  o_wordsWritten
);

  localparam int W = $clog2(DEPTH) + 1;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [8:0]   DEPTH_9 = 9'(DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] COUNT = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  logic [2:0]   r_state;
  logic [W-1:0] r_count;
  logic [W-1:0] r_wordsWritten;
  logic [1:0]   r_byteIdx;
  logic [23:0]  r_asm;
  logic [7:0]   r_checksum;
  logic         r_memWriteEnable;
  logic [31:0]  r_memAddress;
  logic [31:0]  r_memWriteData;
  logic         r_cpuHold;
  logic         r_done;
  logic         r_error;

  logic         w_ready;
  logic         w_accept;
  logic         w_countBad;
  logic         w_lastWord;
  logic [31:0]  w_wordOffset;

  assign w_ready      = (r_state == COUNT) || (r_state == DATA) || (r_state == CHECK);
  assign w_accept     = bus.byteValid && w_ready;
  assign w_countBad   = (bus.byteIn == 8'd0) || ({1'b0, bus.byteIn} > DEPTH_9);
  assign w_lastWord   = (r_wordsWritten + ONE) == r_count;
  assign w_wordOffset = {{(30 - W){1'b0}}, r_wordsWritten, 2'b00};

  // Count byte fits the word counter because DEPTH is validated against it first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= IDLE;
      r_count          <= '0;
      r_wordsWritten   <= '0;
      r_byteIdx        <= '0;
      r_asm            <= '0;
      r_checksum       <= '0;
      r_memWriteEnable <= 1'b0;
      r_memAddress     <= BASE_ADDRESS;
      r_memWriteData   <= '0;
      r_cpuHold        <= 1'b0;
      r_done           <= 1'b0;
      r_error          <= 1'b0;
    end else begin
      r_memWriteEnable <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (i_start) begin
            r_state        <= COUNT;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_wordsWritten <= '0;
            r_checksum     <= '0;
            r_byteIdx      <= '0;
            r_cpuHold      <= 1'b1;
          end
        end
        COUNT: begin
          if (w_accept) begin
            if (w_countBad) begin
              r_state <= ERR;
              r_error <= 1'b1;
            end else begin
              r_count <= bus.byteIn[W-1:0];
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_accept) begin
            r_asm      <= {r_asm[15:0], bus.byteIn};
            r_checksum <= r_checksum ^ bus.byteIn;
            r_byteIdx  <= r_byteIdx + 2'd1;
            if (r_byteIdx == 2'd3) begin
              r_memWriteEnable <= 1'b1;
              r_memAddress     <= BASE_ADDRESS + w_wordOffset;
              r_memWriteData   <= {r_asm, bus.byteIn};
              r_wordsWritten   <= r_wordsWritten + ONE;
              if (w_lastWord) r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (w_accept) begin
            if (bus.byteIn == r_checksum) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_cpuHold <= 1'b0;
            end else begin
              r_state <= ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.byteReady      = w_ready;
  assign bus.memWriteEnable = r_memWriteEnable;
  assign bus.memAddress     = r_memAddress;
  assign bus.memWriteData   = r_memWriteData;
  assign o_cpuHold          = r_cpuHold;
  assign o_busy             = w_ready;
  assign o_done             = r_done;
  assign o_error            = r_error;
  assign o_wordsWritten     = r_wordsWritten;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: framed loads, bad checksum and count, full-depth
// streaming, reset mid-load and ignored Start pulses, with hand-computed expectations.
module tb_instruction_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cpuHold, busy, done, error;
  logic [5:0] wordsWritten;

  instruction_loader_if bus ();

  instruction_loader #(.DEPTH(32), .BASE_ADDRESS(32'h0)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .bus            (bus.slave),
    .o_cpuHold      (cpuHold),
    .o_busy         (busy),
    .o_done         (done),
    .o_error        (error),
    .o_wordsWritten (wordsWritten)
  );

  always #5 clk = ~clk;

  int          assertCount = 0;
  int          failCount   = 0;
  int          cycleCount  = 0;
  int          wrCount     = 0;
  logic [31:0] wrAddr [0:127];
  logic [31:0] wrData [0:127];
  logic [7:0]  frame [$];

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Capture every write strobe mid-cycle, well away from the edge that launched it.
  always @(negedge clk) begin
    if (bus.memWriteEnable && wrCount < 128) begin
      wrAddr[wrCount] = bus.memAddress;
      wrData[wrCount] = bus.memWriteData;
      wrCount = wrCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte, optionally after an idle gap during which Start may be pulsed.
  task automatic sendByte(input logic [7:0] b, input int gap, input bit startInGap);
    bit accepted;
    bus.byteValid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = startInGap && (g == 0);
      @(negedge clk);
    end
    start = 1'b0;
    bus.byteIn    = b;
    bus.byteValid = 1'b1;
    accepted = 1'b0;
    for (int t = 0; t < 50 && !accepted; t++) begin
      if (bus.byteReady) accepted = 1'b1;
      @(negedge clk);
    end
    if (!accepted) checkOutput("byteTimeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input int gapEvery, input bit startInGap);
    for (int i = 0; i < frame.size(); i++) begin
      if (gapEvery > 0 && (i % gapEvery) == gapEvery - 1)
        sendByte(frame[i], 2, startInGap);
      else
        sendByte(frame[i], 0, 1'b0);
    end
    bus.byteValid = 1'b0;
    #1;
  endtask

  task automatic loadTestOneFrame(input logic [7:0] chk);
    frame = '{8'h02, 8'h24, 8'h02, 8'h00, 8'h08, 8'h24, 8'h03, 8'h00, 8'h0C};
    frame.push_back(chk);
  endtask

  task automatic checkTestOne(input string tag, input int base);
    checkOutput({tag, "_wr"},    32'(wrCount - base), 32'd2);
    checkOutput({tag, "_addr0"}, wrAddr[base],        32'h0000_0000);
    checkOutput({tag, "_data0"}, wrData[base],        32'h2402_0008);
    checkOutput({tag, "_addr1"}, wrAddr[base + 1],    32'h0000_0004);
    checkOutput({tag, "_data1"}, wrData[base + 1],    32'h2403_000C);
    checkOutput({tag, "_done"},  32'(done),           32'd1);
    checkOutput({tag, "_error"}, 32'(error),          32'd0);
    checkOutput({tag, "_hold"},  32'(cpuHold),        32'd0);
    checkOutput({tag, "_words"}, 32'(wordsWritten),   32'd2);
  endtask

  initial begin
    int base;
    int t0;
    logic [7:0] chk;

    bus.byteIn    = 8'h00;
    bus.byteValid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_ready", 32'(bus.byteReady),      32'd0);
    checkOutput("rst_we",    32'(bus.memWriteEnable), 32'd0);
    checkOutput("rst_addr",  bus.memAddress,          32'h0);
    checkOutput("rst_data",  bus.memWriteData,        32'h0);
    checkOutput("rst_flags", 32'({cpuHold, busy, done, error}), 32'd0);
    checkOutput("rst_words", 32'(wordsWritten),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] test 1: good two-word frame");
    base = wrCount;
    pulseStart();
    checkOutput("t1_busy", 32'(busy),    32'd1);
    checkOutput("t1_hold", 32'(cpuHold), 32'd1);
    loadTestOneFrame(8'h05);
    applyStimulus(0, 1'b0);
    checkTestOne("t1", base);
    checkOutput("t1_busyEnd", 32'(busy), 32'd0);

    $display("[TB] test 2: bad checksum");
    base = wrCount;
    @(negedge clk);
    pulseStart();
    checkOutput("t2_doneCleared", 32'(done), 32'd0);
    loadTestOneFrame(8'h06);
    applyStimulus(0, 1'b0);
    checkOutput("t2_wr",    32'(wrCount - base), 32'd2);
    checkOutput("t2_error", 32'(error),          32'd1);
    checkOutput("t2_done",  32'(done),           32'd0);
    checkOutput("t2_hold",  32'(cpuHold),        32'd1);

    $display("[TB] test 3: illegal counts");
    for (int k = 0; k < 2; k++) begin
      base = wrCount;
      @(negedge clk);
      pulseStart();
      frame = '{(k == 0) ? 8'd0 : 8'd33};
      applyStimulus(0, 1'b0);
      checkOutput("t3_error", 32'(error),           32'd1);
      checkOutput("t3_ready", 32'(bus.byteReady),   32'd0);
      checkOutput("t3_hold",  32'(cpuHold),         32'd1);
      bus.byteIn    = 8'h01;
      bus.byteValid = 1'b1;
      repeat (3) @(negedge clk);
      bus.byteValid = 1'b0;
      #1;
      checkOutput("t3_noWrite", 32'(wrCount - base), 32'd0);
      checkOutput("t3_stillErr", 32'({busy, error}), 32'd1);
    end

    $display("[TB] test 4: full depth, back-to-back bytes");
    base = wrCount;
    @(negedge clk);
    pulseStart();
    frame = '{8'd32};
    chk = 8'h00;
    for (int i = 0; i < 128; i++) begin
      frame.push_back(8'(i));
      chk = chk ^ 8'(i);
    end
    frame.push_back(chk);
    t0 = cycleCount;
    applyStimulus(0, 1'b0);
    checkOutput("t4_cycles",   32'(cycleCount - t0),  32'd130);
    checkOutput("t4_wr",       32'(wrCount - base),   32'd32);
    checkOutput("t4_addr5",    wrAddr[base + 5],      32'h0000_0014);
    checkOutput("t4_data5",    wrData[base + 5],      32'h1415_1617);
    checkOutput("t4_lastAddr", wrAddr[base + 31],     32'h0000_007C);
    checkOutput("t4_lastData", wrData[base + 31],     32'h7C7D_7E7F);
    checkOutput("t4_done",     32'(done),             32'd1);
    checkOutput("t4_words",    32'(wordsWritten),     32'd32);

    $display("[TB] test 5: reset mid-load");
    base = wrCount;
    @(negedge clk);
    pulseStart();
    frame = '{8'd3, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0, 8'hC1};
    applyStimulus(0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("t5_wr",    32'(wrCount - base),           32'd2);
    checkOutput("t5_we",    32'(bus.memWriteEnable),       32'd0);
    checkOutput("t5_ready", 32'(bus.byteReady),            32'd0);
    checkOutput("t5_addr",  bus.memAddress,                32'h0);
    checkOutput("t5_data",  bus.memWriteData,              32'h0);
    checkOutput("t5_flags", 32'({cpuHold, busy, done, error}), 32'd0);
    checkOutput("t5_words", 32'(wordsWritten),             32'd0);
    rst = 1'b0;
    @(negedge clk);
    base = wrCount;
    pulseStart();
    frame = '{8'd1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    applyStimulus(0, 1'b0);
    checkOutput("t5_reWr",   32'(wrCount - base), 32'd1);
    checkOutput("t5_reAddr", wrAddr[base],        32'h0);
    checkOutput("t5_reData", wrData[base],        32'h1122_3344);
    checkOutput("t5_reDone", 32'(done),           32'd1);

    $display("[TB] test 6: Start pulses and gaps during load");
    base = wrCount;
    @(negedge clk);
    pulseStart();
    loadTestOneFrame(8'h05);
    applyStimulus(3, 1'b1);
    checkTestOne("t6", base);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
